alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_pkg.sv | 38 +++
 rtl/alu_arbiter_alu.sv | 52 +++++
 rtl/alu_arbiter.sv | 108 ++++++++++
 tb/tb_alu_arbiter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: data width,
// ALUFun codes, FSM state encoding and the supported-code check.
package alu_arbiter_pkg;

  localparam int unsigned ALU_WIDTH = 32;

  localparam logic [5:0] FUN_ADD  = 6'b000000;
  localparam logic [5:0] FUN_SUB  = 6'b000001;
  localparam logic [5:0] FUN_AND  = 6'b011000;
  localparam logic [5:0] FUN_OR   = 6'b011110;
  localparam logic [5:0] FUN_XOR  = 6'b010110;
  localparam logic [5:0] FUN_NOR  = 6'b010001;
  localparam logic [5:0] FUN_PASA = 6'b011010;
  localparam logic [5:0] FUN_SLL  = 6'b100000;
  localparam logic [5:0] FUN_SRL  = 6'b100001;
  localparam logic [5:0] FUN_SRA  = 6'b100011;
  localparam logic [5:0] FUN_EQ   = 6'b110011;
  localparam logic [5:0] FUN_NE   = 6'b110001;
  localparam logic [5:0] FUN_LT   = 6'b110101;
  localparam logic [5:0] FUN_LEZ  = 6'b111101;
  localparam logic [5:0] FUN_LTZ  = 6'b111011;
  localparam logic [5:0] FUN_GTZ  = 6'b111111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // True for every ALUFun code the ALU implements.
  function automatic logic fun_supported(input logic [5:0] fun);
    case (fun)
      FUN_ADD, FUN_SUB, FUN_AND, FUN_OR, FUN_XOR, FUN_NOR, FUN_PASA,
      FUN_SLL, FUN_SRL, FUN_SRA, FUN_EQ, FUN_NE, FUN_LT, FUN_LEZ,
      FUN_LTZ, FUN_GTZ: fun_supported = 1'b1;
      default:          fun_supported = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU: arithmetic, logic, shifts (amount a[4:0] applied to b)
// and compares (0/1 in bit 0). Sign selects signed compares.
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sign,
  input  logic [5:0]       alufun,
  output logic [WIDTH-1:0] s
);

  logic lt;
  logic lez;
  logic ltz;
  logic gtz;

  // Compare flags; without sign, A is treated as unsigned (never negative).
  always_comb begin
    lt  = sign ? ($signed(a) < $signed(b)) : (a < b);
    ltz = sign & a[WIDTH-1];
    lez = ltz | (a == '0);
    gtz = ~ltz & (a != '0);
  end

  // Result select by ALUFun; unknown codes produce zero.
  always_comb begin
    s = '0;
    case (alufun)
      FUN_ADD:  s = a + b;
      FUN_SUB:  s = a - b;
      FUN_AND:  s = a & b;
      FUN_OR:   s = a | b;
      FUN_XOR:  s = a ^ b;
      FUN_NOR:  s = ~(a | b);
      FUN_PASA: s = a;
      FUN_SLL:  s = b << a[4:0];
      FUN_SRL:  s = b >> a[4:0];
      FUN_SRA:  s = $signed(b) >>> a[4:0];
      FUN_EQ:   s = {{(WIDTH-1){1'b0}}, (a == b)};
      FUN_NE:   s = {{(WIDTH-1){1'b0}}, (a != b)};
      FUN_LT:   s = {{(WIDTH-1){1'b0}}, lt};
      FUN_LEZ:  s = {{(WIDTH-1){1'b0}}, lez};
      FUN_LTZ:  s = {{(WIDTH-1){1'b0}}, ltz};
      FUN_GTZ:  s = {{(WIDTH-1){1'b0}}, gtz};
      default:  s = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared ALU. One operation in flight:
// IDLE grants and latches operands, EXEC registers the ALU result,
// RESP holds it until the owning requester takes it. Round-robin priority.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [WIDTH-1:0] r0_a,
  input  logic [WIDTH-1:0] r0_b,
  input  logic             r0_sign,
  input  logic [5:0]       r0_fun,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [WIDTH-1:0] r1_a,
  input  logic [WIDTH-1:0] r1_b,
  input  logic             r1_sign,
  input  logic [5:0]       r1_fun,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err
);

  logic [1:0]       state;
  logic             pri;
  logic             id;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             sign_q;
  logic [5:0]       fun_q;
  logic             gnt;
  logic             accept;
  logic             rsp_hs;
  logic [WIDTH-1:0] alu_s;

  // Grant selection: a lone requester wins outright, a tie goes to pri.
  always_comb begin
    gnt = 1'b0;
    if (r0_valid && r1_valid) gnt = pri;
    else if (r1_valid)        gnt = 1'b1;
  end

  // Handshake signals; ready only in IDLE and never during reset.
  always_comb begin
    r0_ready   = (state == ST_IDLE) && !reset && r0_valid && !gnt;
    r1_ready   = (state == ST_IDLE) && !reset && r1_valid && gnt;
    accept     = r0_ready || r1_ready;
    rsp0_valid = (state == ST_RESP) && !id;
    rsp1_valid = (state == ST_RESP) && id;
    rsp_hs     = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);
  end

  alu_arbiter_alu #(.WIDTH(WIDTH)) u_alu (
    .a      (a_q),
    .b      (b_q),
    .sign   (sign_q),
    .alufun (fun_q),
    .s      (alu_s)
  );

  // Control FSM, operand latch and registered response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      pri      <= 1'b0;
      id       <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      sign_q   <= 1'b0;
      fun_q    <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            id     <= gnt;
            a_q    <= gnt ? r1_a    : r0_a;
            b_q    <= gnt ? r1_b    : r0_b;
            sign_q <= gnt ? r1_sign : r0_sign;
            fun_q  <= gnt ? r1_fun  : r0_fun;
            state  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_data <= fun_supported(fun_q) ? alu_s : '0;
          rsp_err  <= ~fun_supported(fun_q);
          state    <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_hs) begin
            pri   <= ~id;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with hand-computed expected results.
module tb_alu_arbiter;

  logic        clk;
  logic        reset;
  logic        r0_valid, r1_valid;
  logic        r0_ready, r1_ready;
  logic [31:0] r0_a, r0_b, r1_a, r1_b;
  logic        r0_sign, r1_sign;
  logic [5:0]  r0_fun, r1_fun;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready, rsp1_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;

  int tests  = 0;
  int failed = 0;

  alu_arbiter #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .r0_valid   (r0_valid),
    .r0_ready   (r0_ready),
    .r0_a       (r0_a),
    .r0_b       (r0_b),
    .r0_sign    (r0_sign),
    .r0_fun     (r0_fun),
    .r1_valid   (r1_valid),
    .r1_ready   (r1_ready),
    .r1_a       (r1_a),
    .r1_b       (r1_b),
    .r1_sign    (r1_sign),
    .r1_fun     (r1_fun),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Lone-requester operation: accept, check N+1 / N+2 behaviour, take result.
  task automatic run_op(input string tag, input logic id, input logic [31:0] a,
                        input logic [31:0] b, input logic sg, input logic [5:0] fn,
                        input logic [31:0] exp_d, input logic exp_e);
    int n;
    if (id) begin
      r1_valid = 1'b1; r1_a = a; r1_b = b; r1_sign = sg; r1_fun = fn;
    end else begin
      r0_valid = 1'b1; r0_a = a; r0_b = b; r0_sign = sg; r0_fun = fn;
    end
    #1;
    n = 0;
    while (((id ? r1_ready : r0_ready) !== 1'b1) && n < 8) begin
      tick;
      n++;
    end
    chk({tag, " ready"}, {31'd0, (id ? r1_ready : r0_ready)}, 32'd1);
    tick;
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    chk({tag, " exec"}, {28'd0, r0_ready, r1_ready, rsp0_valid, rsp1_valid}, 32'd0);
    tick;
    chk({tag, " rspvalid"}, {30'd0, rsp1_valid, rsp0_valid}, id ? 32'd2 : 32'd1);
    chk({tag, " data"}, rsp_data, exp_d);
    chk({tag, " err"}, {31'd0, rsp_err}, {31'd0, exp_e});
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    tick;
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    chk({tag, " done"}, {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    r0_valid = 1'b1; r1_valid = 1'b1;
    r0_a = '0; r0_b = '0; r0_sign = 1'b0; r0_fun = '0;
    r1_a = '0; r1_b = '0; r1_sign = 1'b0; r1_fun = '0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    tick;
    tick;
    chk("reset ready", {30'd0, r0_ready, r1_ready}, 32'd0);
    chk("reset rspvalid", {30'd0, rsp0_valid, rsp1_valid}, 32'd0);
    chk("reset data", rsp_data, 32'd0);
    chk("reset err", {31'd0, rsp_err}, 32'd0);
    r0_valid = 1'b0; r1_valid = 1'b0;
    reset = 1'b0;
    tick;

    run_op("add r0", 1'b0, 32'd8, 32'h1FF, 1'b1, 6'b000000, 32'h0000_0207, 1'b0);
    run_op("sub r1", 1'b1, 32'd8, 32'h1FF, 1'b0, 6'b000001, 32'hFFFF_FE09, 1'b0);
    // pri now points at r1's opponent (r0); a lone r1 must still be granted.
    run_op("and lone r1", 1'b1, 32'h0000_F0F0, 32'h0000_FF00, 1'b0, 6'b011000, 32'h0000_F000, 1'b0);

    // Round robin with both requesters permanently valid.
    reset = 1'b1;
    tick;
    reset = 1'b0;
    r0_valid = 1'b1; r0_a = 32'd3;    r0_b = 32'd4;    r0_sign = 1'b0; r0_fun = 6'b000000;
    r1_valid = 1'b1; r1_a = 32'h0FF;  r1_b = 32'h00F;  r1_sign = 1'b0; r1_fun = 6'b010110;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("rr grant", {30'd0, r1_ready, r0_ready}, (k % 2 == 1) ? 32'd2 : 32'd1);
      tick;
      chk("rr exec ready", {30'd0, r1_ready, r0_ready}, 32'd0);
      tick;
      chk("rr rspvalid", {30'd0, rsp1_valid, rsp0_valid}, (k % 2 == 1) ? 32'd2 : 32'd1);
      chk("rr data", rsp_data, (k % 2 == 1) ? 32'h0000_00F0 : 32'd7);
      chk("rr resp ready", {30'd0, r1_ready, r0_ready}, 32'd0);
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      tick;
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      #1;
    end

    // Response stall: r0 granted (pri back to 0), rsp0_ready withheld 5 cycles.
    r0_a = 32'h0F0F_0000; r0_b = 32'h0000_00FF; r0_fun = 6'b011110;
    chk("stall grant", {30'd0, r1_ready, r0_ready}, 32'd1);
    tick;
    r0_valid = 1'b0;
    tick;
    for (int k = 0; k < 5; k++) begin
      chk("stall rspvalid", {30'd0, rsp1_valid, rsp0_valid}, 32'd1);
      chk("stall data", rsp_data, 32'h0F0F_00FF);
      chk("stall ready", {30'd0, r1_ready, r0_ready}, 32'd0);
      tick;
    end
    r1_valid = 1'b0;
    rsp0_ready = 1'b1;
    tick;
    rsp0_ready = 1'b0;
    chk("stall done", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);

    run_op("bad fun", 1'b0, 32'd5, 32'd6, 1'b0, 6'b000010, 32'd0, 1'b1);
    run_op("sll", 1'b0, 32'd4, 32'd1, 1'b0, 6'b100000, 32'h0000_0010, 1'b0);
    run_op("lt signed", 1'b1, 32'hFFFF_FFFF, 32'd1, 1'b1, 6'b110101, 32'd1, 1'b0);
    run_op("lt unsigned", 1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0, 6'b110101, 32'd0, 1'b0);
    run_op("sra", 1'b1, 32'd4, 32'h8000_0000, 1'b0, 6'b100011, 32'hF800_0000, 1'b0);
    run_op("eq", 1'b0, 32'd5, 32'd5, 1'b0, 6'b110011, 32'd1, 1'b0);
    run_op("nor", 1'b1, 32'd0, 32'hFFFF_0000, 1'b0, 6'b010001, 32'h0000_FFFF, 1'b0);

    // Reset while r1's operation is in EXEC: it must vanish.
    r1_valid = 1'b1; r1_a = 32'd1; r1_b = 32'd2; r1_sign = 1'b0; r1_fun = 6'b000000;
    #1;
    chk("rst r1 ready", {31'd0, r1_ready}, 32'd1);
    tick;
    reset = 1'b1;
    r0_valid = 1'b1;
    #1;
    chk("rst ready low", {30'd0, r1_ready, r0_ready}, 32'd0);
    tick;
    chk("rst rspvalid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    chk("rst data", rsp_data, 32'd0);
    chk("rst err", {31'd0, rsp_err}, 32'd0);
    r0_valid = 1'b0; r1_valid = 1'b0;
    reset = 1'b0;
    tick;
    chk("rst no rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    r0_valid = 1'b1; r0_a = 32'd10; r0_b = 32'd20; r0_sign = 1'b0; r0_fun = 6'b000000;
    r1_valid = 1'b1;
    #1;
    chk("rst pri grant", {30'd0, r1_ready, r0_ready}, 32'd1);
    r1_valid = 1'b0;
    run_op("post rst add", 1'b0, 32'd10, 32'd20, 1'b0, 6'b000000, 32'd30, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
